// File: rtl/usb_fs_line_tx_if.sv
// usb_fs_line_tx_if: byte handshake plus line-drive bundle of the
// full-speed USB line transmitter. The link side uses the master modport,
// the transmitter uses the slave modport.
interface usb_fs_line_tx_if;
  logic [7:0] DataOut_i;
  logic       TxValid_i;
  logic       TxReady_o;
  logic       line_dp;
  logic       line_dn;
  logic       line_d;
  logic       line_oe;
  logic       busy_o;

  modport master (
    output DataOut_i,
    output TxValid_i,
    input  TxReady_o,
    input  line_dp,
    input  line_dn,
    input  line_d,
    input  line_oe,
    input  busy_o
  );

  modport slave (
    input  DataOut_i,
    input  TxValid_i,
    output TxReady_o,
    output line_dp,
    output line_dn,
    output line_d,
    output line_oe,
    output busy_o
  );
endinterface

// File: rtl/usb_fs_line_tx.sv
// usb_fs_line_tx: full-speed USB 1.1 serial line transmitter.
// Sends SYNC, NRZI-coded bit-stuffed data bytes (LSB first) and EOP on D+/D-.
// Each line bit lasts CLKS_PER_BIT clocks. Line outputs are registered and
// move on the clock after a bit boundary. TxReady_o is high during the last
// clock of a byte (or of its trailing stuff bit) while TxValid_i is high, and
// DataOut_i is captured on the edge that closes that clock.
module usb_fs_line_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  usb_fs_line_tx_if.slave   bus
);

  localparam int              TW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0]   TMAX = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0]   TONE = TW'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_DATA    = 3'd2,
    ST_EOP_SE0 = 3'd3,
    ST_EOP_J   = 3'd4
  } state_t;

  // NRZI: a 0 toggles the line level, a 1 holds it.
  function automatic logic nrzi_level(input logic cur_level, input logic bit_val);
    return bit_val ? cur_level : ~cur_level;
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;

  logic [TW-1:0]   r_timer;     // position inside the current bit period
  logic [2:0]      r_idx;       // SYNC/data bit index, or EOP SE0 bit count
  logic [2:0]      r_ones;      // consecutive ones put on the line
  logic [7:0]      r_shift;     // remaining data bits, next one in bit 0
  logic            r_stuff;     // the bit on the line is a stuff bit
  logic            r_dp;
  logic            r_dn;
  logic            r_oe;

  logic [TW-1:0]   w_timer_nxt;
  logic [2:0]      w_idx_nxt;
  logic [2:0]      w_ones_nxt;
  logic [7:0]      w_shift_nxt;
  logic            w_stuff_nxt;
  logic            w_dp_nxt;
  logic            w_dn_nxt;
  logic            w_oe_nxt;

  logic            w_tick;      // last clock of the current bit period
  logic            w_stuff_due; // six ones sent: a stuff bit must follow
  logic            w_byte_end;  // last clock of SYNC or of a byte incl. trailing stuff
  logic            w_launch;    // a J/K bit is launched on the next edge
  logic            w_bit;       // value of the launched bit before NRZI
  logic            w_tx_ready;
  logic            w_busy;

  assign w_tick      = (r_state != ST_IDLE) && (r_timer == TMAX);
  assign w_stuff_due = (r_ones == 3'd6);
  assign w_byte_end  = w_tick &&
                       (((r_state == ST_SYNC) && (r_idx == 3'd7)) ||
                        ((r_state == ST_DATA) && (r_idx == 3'd7) && (r_stuff || !w_stuff_due)));

  // State register with asynchronous return to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode: packet framing from SYNC through EOP.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.TxValid_i) begin
          w_state_nxt = ST_SYNC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SYNC, ST_DATA: begin
        if (w_byte_end) begin
          w_state_nxt = bus.TxValid_i ? ST_DATA : ST_EOP_SE0;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_EOP_SE0: begin
        if (w_tick && (r_idx == 3'd1)) begin
          w_state_nxt = ST_EOP_J;
        end else begin
          w_state_nxt = ST_EOP_SE0;
        end
      end
      ST_EOP_J: begin
        if (w_tick) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_EOP_J;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode: handshake pulse and busy flag.
  always_comb begin
    w_tx_ready = 1'b0;
    w_busy     = 1'b0;
    case (r_state)
      ST_SYNC, ST_DATA: begin
        w_tx_ready = w_byte_end & bus.TxValid_i;
        w_busy     = 1'b1;
      end
      ST_EOP_SE0, ST_EOP_J: begin
        w_tx_ready = 1'b0;
        w_busy     = 1'b1;
      end
      default: begin
        w_tx_ready = 1'b0;
        w_busy     = 1'b0;
      end
    endcase
  end

  // Datapath next values: bit timer, bit selection, stuffing and line levels.
  always_comb begin
    w_timer_nxt = r_timer;
    w_idx_nxt   = r_idx;
    w_ones_nxt  = r_ones;
    w_shift_nxt = r_shift;
    w_stuff_nxt = r_stuff;
    w_dp_nxt    = r_dp;
    w_dn_nxt    = r_dn;
    w_oe_nxt    = r_oe;
    w_launch    = 1'b0;
    w_bit       = 1'b0;

    if (r_state == ST_IDLE) begin
      w_timer_nxt = '0;
    end else if (w_tick) begin
      w_timer_nxt = '0;
    end else begin
      w_timer_nxt = r_timer + TONE;
    end

    case (r_state)
      ST_IDLE: begin
        if (bus.TxValid_i) begin
          // First SYNC bit is a 0, i.e. K after the idle J.
          w_launch    = 1'b1;
          w_bit       = 1'b0;
          w_idx_nxt   = 3'd0;
          w_stuff_nxt = 1'b0;
          w_oe_nxt    = 1'b1;
        end else begin
          w_dp_nxt = 1'b1;
          w_dn_nxt = 1'b0;
          w_oe_nxt = 1'b0;
        end
      end
      ST_SYNC, ST_DATA: begin
        if (!w_tick) begin
          w_launch = 1'b0;
        end else if (w_byte_end) begin
          if (bus.TxValid_i) begin
            w_launch    = 1'b1;
            w_bit       = bus.DataOut_i[0];
            w_shift_nxt = {1'b0, bus.DataOut_i[7:1]};
            w_idx_nxt   = 3'd0;
            w_stuff_nxt = 1'b0;
          end else begin
            w_dp_nxt    = 1'b0;
            w_dn_nxt    = 1'b0;
            w_idx_nxt   = 3'd0;
            w_stuff_nxt = 1'b0;
          end
        end else if (r_state == ST_SYNC) begin
          // SYNC pattern 0000_0001: only the eighth bit is a 1.
          w_launch  = 1'b1;
          w_bit     = (r_idx == 3'd6);
          w_idx_nxt = r_idx + 3'd1;
        end else if (w_stuff_due && !r_stuff) begin
          w_launch    = 1'b1;
          w_bit       = 1'b0;
          w_stuff_nxt = 1'b1;
        end else begin
          w_launch    = 1'b1;
          w_bit       = r_shift[0];
          w_shift_nxt = {1'b0, r_shift[7:1]};
          w_idx_nxt   = r_idx + 3'd1;
          w_stuff_nxt = 1'b0;
        end
      end
      ST_EOP_SE0: begin
        if (!w_tick) begin
          w_launch = 1'b0;
        end else if (r_idx == 3'd1) begin
          w_dp_nxt  = 1'b1;
          w_dn_nxt  = 1'b0;
          w_idx_nxt = 3'd0;
        end else begin
          w_idx_nxt = r_idx + 3'd1;
        end
      end
      ST_EOP_J: begin
        if (w_tick) begin
          w_dp_nxt = 1'b1;
          w_dn_nxt = 1'b0;
          w_oe_nxt = 1'b0;
        end else begin
          w_launch = 1'b0;
        end
      end
      default: begin
        w_timer_nxt = '0;
        w_idx_nxt   = 3'd0;
        w_shift_nxt = 8'd0;
        w_stuff_nxt = 1'b0;
        w_dp_nxt    = 1'b1;
        w_dn_nxt    = 1'b0;
        w_oe_nxt    = 1'b0;
      end
    endcase

    if (w_launch) begin
      w_dp_nxt   = nrzi_level(r_dp, w_bit);
      w_dn_nxt   = ~nrzi_level(r_dp, w_bit);
      w_ones_nxt = w_bit ? (r_ones + 3'd1) : 3'd0;
    end else begin
      w_ones_nxt = r_ones;
    end
  end

  // Datapath and line registers; reset drives an idle J with the bus released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_timer <= '0;
      r_idx   <= 3'd0;
      r_ones  <= 3'd0;
      r_shift <= 8'd0;
      r_stuff <= 1'b0;
      r_dp    <= 1'b1;
      r_dn    <= 1'b0;
      r_oe    <= 1'b0;
    end else begin
      r_timer <= w_timer_nxt;
      r_idx   <= w_idx_nxt;
      r_ones  <= w_ones_nxt;
      r_shift <= w_shift_nxt;
      r_stuff <= w_stuff_nxt;
      r_dp    <= w_dp_nxt;
      r_dn    <= w_dn_nxt;
      r_oe    <= w_oe_nxt;
    end
  end

  assign bus.TxReady_o = w_tx_ready;
  assign bus.busy_o    = w_busy;
  assign bus.line_dp   = r_dp;
  assign bus.line_dn   = r_dn;
  assign bus.line_d    = r_dp;
  assign bus.line_oe   = r_oe;

endmodule

// File: tb/tb_usb_fs_line_tx.sv
// tb_usb_fs_line_tx: checks usb_fs_line_tx against a symbol-level packet
// model (SYNC, NRZI, bit stuffing, EOP) built from plain queues.
module tb_usb_fs_line_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  usb_fs_line_tx_if bus ();

  usb_fs_line_tx #(.CLKS_PER_BIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] pkt[$];    // bytes of the packet being sent
  logic [7:0] npkt[$];   // next packet
  int         syms[$];   // expected line symbols per bit: 0=SE0 1=J 2=K
  int         rdy[$];    // expected TxReady sample index per byte

  task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at sample %0d: got %0h, want %0h", name, n, act, exp);
    end
  endtask

  task automatic chk_s(input string name, input string act, input string exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %s, want %s", name, act, exp);
    end
  endtask

  // One protocol bit: NRZI level, ones run, stuff bit right after a sixth one.
  task automatic push_bit(input int bv, inout int lvl, inout int ones);
    if (bv == 0) begin
      lvl  = (lvl == 1) ? 2 : 1;
      ones = 0;
    end else begin
      ones++;
    end
    syms.push_back(lvl);
    if (ones == 6) begin
      lvl  = (lvl == 1) ? 2 : 1;
      ones = 0;
      syms.push_back(lvl);
    end
  endtask

  task automatic build_model();
    int lvl;
    int ones;
    lvl  = 1;
    ones = 0;
    syms.delete();
    rdy.delete();
    for (int i = 0; i < 8; i++) push_bit((i == 7) ? 1 : 0, lvl, ones);
    for (int k = 0; k < pkt.size(); k++) begin
      rdy.push_back(4 * syms.size() - 1);
      for (int j = 0; j < 8; j++) push_bit(int'(pkt[k][j]), lvl, ones);
    end
    syms.push_back(0);
    syms.push_back(0);
    syms.push_back(1);
  endtask

  task automatic sym_str(output string s);
    s = "";
    foreach (syms[i]) begin
      if (syms[i] == 1) s = {s, "J"};
      else if (syms[i] == 2) s = {s, "K"};
      else s = {s, "0"};
    end
  endtask

  task automatic chk_idle(input string name, input int n);
    chk({name, "_oe"},   n, 32'(bus.line_oe),   32'd0);
    chk({name, "_dp"},   n, 32'(bus.line_dp),   32'd1);
    chk({name, "_dn"},   n, 32'(bus.line_dn),   32'd0);
    chk({name, "_busy"}, n, 32'(bus.busy_o),    32'd0);
    chk({name, "_rdy"},  n, 32'(bus.TxReady_o), 32'd0);
  endtask

  // Sends pkt and compares every clock. Entry just after a posedge.
  // chained: the DUT already sampled TxValid on the previous edge.
  // chain_next: raise TxValid with next_first during this packet's EOP.
  // abort_at: sample index at which rst is pulsed instead of finishing.
  task automatic run_packet(input bit chained, input logic [7:0] next_first, input bit chain_next,
                            input int abort_at, output int n_rdy, output int n_oe);
    int L;
    int k;
    int last_bound;
    int sym;
    int eoe;
    int er;
    build_model();
    L          = 4 * syms.size() + 1;
    last_bound = 4 * (syms.size() - 3) - 1;
    k          = 0;
    n_rdy      = 0;
    n_oe       = 0;
    if (!chained) begin
      bus.TxValid_i = 1'b1;
      bus.DataOut_i = pkt[0];
      @(posedge clk);
      #1;
    end
    for (int n = 0; n < L; n++) begin
      @(negedge clk);
      if (n == abort_at) begin
        #2 rst = 1'b0;
        #1;
        chk_idle("rst_now", n);
        bus.TxValid_i = 1'b0;
        @(posedge clk);
        #1;
        chk_idle("rst_held", n);
        #2 rst = 1'b1;
        return;
      end
      if (n < L - 1) begin
        sym = syms[n / 4];
        eoe = 1;
      end else begin
        sym = 1;
        eoe = 0;
      end
      er = 0;
      foreach (rdy[i]) if (rdy[i] == n) er = 1;
      chk("oe",   n, 32'(bus.line_oe),   32'(eoe));
      chk("busy", n, 32'(bus.busy_o),    32'(eoe));
      chk("dp",   n, 32'(bus.line_dp),   32'(sym == 1));
      chk("dn",   n, 32'(bus.line_dn),   32'(sym == 2));
      chk("d",    n, 32'(bus.line_d),    32'(sym == 1));
      chk("rdy",  n, 32'(bus.TxReady_o), 32'(er));
      n_rdy += int'(bus.TxReady_o);
      n_oe  += int'(bus.line_oe);
      @(posedge clk);
      #1;
      if (k < pkt.size() && n == rdy[k]) begin
        k++;
        if (k < pkt.size()) begin
          bus.DataOut_i = pkt[k];
        end else begin
          bus.TxValid_i = 1'b0;
          bus.DataOut_i = 8'($urandom);
        end
      end
      if (chain_next && n == last_bound) begin
        bus.TxValid_i = 1'b1;
        bus.DataOut_i = next_first;
      end
    end
  endtask

  function automatic logic [7:0] pick_byte();
    case ($urandom_range(0, 4))
      0: return 8'hFF;
      1: return 8'h7E;
      2: return 8'hFC;
      3: return 8'h3F;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int    nr;
    int    no;
    int    gap;
    bit    chain;
    bit    cur_chained;
    string s;

    rst           = 1'b0;
    bus.TxValid_i = 1'b0;
    bus.DataOut_i = 8'h00;
    #12;
    chk_idle("reset", 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single byte D2.
    pkt = '{8'hD2};
    run_packet(1'b0, 8'h00, 1'b0, -1, nr, no);
    sym_str(s);
    chk_s("d2_symbols", s, "KJKJKJKKJJKJJKKK00J");
    chk("d2_rdy_count", 0, 32'(nr), 32'd1);
    chk("d2_oe_clocks", 0, 32'(no), 32'd76);

    // FF then 00: stuff bit inside FF, second ready 36 clocks later.
    pkt = '{8'hFF, 8'h00};
    run_packet(1'b0, 8'h00, 1'b0, -1, nr, no);
    chk("ff_ready_gap", 0, 32'(rdy[1] - rdy[0]), 32'd36);
    chk("ff_rdy_count", 0, 32'(nr), 32'd2);
    chk("ff_oe_clocks", 0, 32'(no), 32'd112);

    // 7E then FC: FC ends on six ones, stuff bit goes out before SE0.
    pkt = '{8'h7E, 8'hFC};
    run_packet(1'b0, 8'h00, 1'b0, -1, nr, no);
    chk("fc_oe_clocks", 0, 32'(no), 32'd116);

    // TxValid high through EOP, next SYNC right after the single IDLE clock.
    pkt = '{8'hA5};
    run_packet(1'b0, 8'h3C, 1'b1, -1, nr, no);
    pkt = '{8'h3C};
    run_packet(1'b1, 8'h00, 1'b0, -1, nr, no);
    chk("chain_oe_clocks", 0, 32'(no), 32'd76);

    // Reset in the middle of the second data byte, then a clean packet.
    pkt = '{8'h11, 8'h22, 8'h33};
    run_packet(1'b0, 8'h00, 1'b0, 4 * 16 + 6, nr, no);
    @(posedge clk);
    #1;
    pkt = '{8'hC3};
    run_packet(1'b0, 8'h00, 1'b0, -1, nr, no);
    chk("post_rst_rdy", 0, 32'(nr), 32'd1);

    // Randomised packets, some back to back.
    cur_chained = 1'b0;
    pkt.delete();
    for (int i = 0; i < $urandom_range(1, 4); i++) pkt.push_back(pick_byte());
    for (int it = 0; it < 40; it++) begin
      npkt.delete();
      for (int i = 0; i < $urandom_range(1, 4); i++) npkt.push_back(pick_byte());
      chain = (it < 39) && ($urandom_range(0, 2) == 0);
      run_packet(cur_chained, npkt[0], chain, -1, nr, no);
      chk("rand_rdy_count", it, 32'(nr), 32'(pkt.size()));
      if (!chain) begin
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          chk_idle("gap", g);
          @(posedge clk);
          #1;
        end
      end
      pkt         = npkt;
      cur_chained = chain;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
